ir_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 18-bit instruction register. Requests a word from instruction memory at the program counter, then pulses the IR's write and read strobes to load and publish the word. Holds it valid for the execute stage until completion, then advances or branches the PC. Sits between instruction memory, the IR, and the execute/ALU control.

---
 rtl/ir_fetch_ctrl.sv | 101 ++++++++++
 tb/tb_ir_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_ctrl.sv
// Instruction-fetch sequencer for the 18-bit IR: fetches a word at pc, strobes it
// into the IR, holds it for execute, then advances or branches the pc.
module ir_fetch_ctrl #(
    parameter int            AW       = 10,
    parameter int            IW       = 18,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic          wr_IR,
    output logic          re_IR,
    output logic [IW-1:0] IRin,
    output logic          ir_valid,
    input  logic          exec_done,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fault
);

    // The wait counter only ever holds 0..TIMEOUT-1; the last value triggers the fault.
    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_LATCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_data;
    logic [CW-1:0] r_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_data  <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run && !halt) begin
                        r_state <= S_REQ;
                        r_wait  <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_data  <= mem_rdata;
                        r_state <= S_LOAD;
                    end else if (r_wait == W_LAST) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_LOAD:  r_state <= S_LATCH;
                S_LATCH: r_state <= S_EXEC;
                S_EXEC: begin
                    if (exec_done) begin
                        r_pc <= branch_taken ? branch_target : r_pc + AW'(1);
                        if (halt || !run) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_REQ;
                            r_wait  <= '0;
                        end
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every strobe is a pure state decode, so no input reaches an output combinationally.
    assign mem_req  = (r_state == S_REQ);
    assign wr_IR    = (r_state == S_LOAD);
    assign re_IR    = (r_state == S_LATCH);
    assign ir_valid = (r_state == S_EXEC);
    assign fault    = (r_state == S_FAULT);
    assign busy     = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign IRin     = r_data;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed self-checking bench for ir_fetch_ctrl; inputs driven and outputs sampled
// on the falling clock edge.
module tb_ir_fetch_ctrl;

    localparam int AW = 10;
    localparam int IW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          halt = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          wr_IR;
    logic          re_IR;
    logic [IW-1:0] IRin;
    logic          ir_valid;
    logic          exec_done = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          fault;

    int total = 0;
    int bad   = 0;

    ir_fetch_ctrl #(.AW(AW), .IW(IW), .RESET_PC('0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wr_IR(wr_IR), .re_IR(re_IR), .IRin(IRin), .ir_valid(ir_valid),
        .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Drives one full instruction starting in a REQ cycle; reports the address seen
    // and whether every stage strobe appeared on its expected cycle.
    task automatic run_instr(input logic [IW-1:0] data, input int extraExec,
                             input logic bt, input logic [AW-1:0] tgt,
                             output logic [AW-1:0] addrSeen, output logic seqOk,
                             output logic overlap);
        addrSeen = mem_addr;
        seqOk    = mem_req;
        overlap  = 1'b0;
        mem_ack = 1'b1; mem_rdata = data;
        @(negedge clk);
        mem_ack = 1'b0;
        seqOk   = seqOk & wr_IR & ~mem_req & (IRin === data);
        overlap = overlap | (wr_IR & re_IR);
        @(negedge clk);
        seqOk   = seqOk & re_IR & ~wr_IR;
        overlap = overlap | (wr_IR & re_IR);
        @(negedge clk);
        seqOk   = seqOk & ir_valid & ~re_IR;
        for (int i = 0; i < extraExec; i++) begin
            @(negedge clk);
            seqOk = seqOk & ir_valid & ~mem_req;
        end
        exec_done = 1'b1; branch_taken = bt; branch_target = tgt;
        @(negedge clk);
        exec_done = 1'b0; branch_taken = 1'b0;
        seqOk = seqOk & ~ir_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({mem_req, wr_IR, re_IR, ir_valid, busy, fault} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000000", {mem_req, wr_IR, re_IR, ir_valid, busy, fault});
        end
        total++; if (pc !== 10'h000 || mem_addr !== 10'h000 || IRin !== 18'h0) begin
            bad++; $display("FAIL reset_regs: pc=%h addr=%h IRin=%h want 0", pc, mem_addr, IRin);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_fetch();
        run = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== 10'h000) begin
            bad++; $display("FAIL first_req: mem_req=%b addr=%h want 1/000", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 18'h2A5A5;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 18'h00000;
        total++; if (wr_IR !== 1'b1 || IRin !== 18'h2A5A5 || re_IR !== 1'b0) begin
            bad++; $display("FAIL first_load: wr=%b re=%b IRin=%h want 1/0/2a5a5", wr_IR, re_IR, IRin);
        end
        @(negedge clk);
        total++; if (re_IR !== 1'b1 || wr_IR !== 1'b0 || IRin !== 18'h2A5A5) begin
            bad++; $display("FAIL first_latch: re=%b wr=%b IRin=%h want 1/0/2a5a5", re_IR, wr_IR, IRin);
        end
        @(negedge clk);
        total++; if (ir_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL first_exec: ir_valid=%b busy=%b want 1/1", ir_valid, busy);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        total++; if (pc !== 10'h001 || mem_req !== 1'b1 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL first_advance: pc=%h mem_req=%b ir_valid=%b want 001/1/0", pc, mem_req, ir_valid);
        end
    endtask

    task automatic test_straight_line();
        logic [AW-1:0] a;
        logic          ok, ov;
        for (int i = 0; i < 4; i++) begin
            run_instr(18'h10000 + IW'(i), 1, 1'b0, '0, a, ok, ov);
            total++; if (a !== AW'(i + 1) || !ok || ov) begin
                bad++; $display("FAIL straight_%0d: addr=%h ok=%b overlap=%b want %h/1/0", i, a, ok, ov, AW'(i + 1));
            end
        end
        total++; if (pc !== 10'h005 || mem_req !== 1'b1) begin
            bad++; $display("FAIL straight_end: pc=%h mem_req=%b want 005/1", pc, mem_req);
        end
    endtask

    task automatic test_branch();
        logic [AW-1:0] a;
        logic          ok, ov;
        run_instr(18'h3FFFF, 0, 1'b1, 10'h3F0, a, ok, ov);
        total++; if (a !== 10'h005 || !ok || mem_addr !== 10'h3F0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL branch_taken: from=%h next=%h ok=%b want 005/3f0/1", a, mem_addr, ok);
        end
        run_instr(18'h12345, 0, 1'b1, 10'h3FF, a, ok, ov);
        total++; if (a !== 10'h3F0 || pc !== 10'h3FF) begin
            bad++; $display("FAIL branch_second: from=%h pc=%h want 3f0/3ff", a, pc);
        end
        run_instr(18'h00001, 2, 1'b0, 10'h155, a, ok, ov);
        total++; if (a !== 10'h3FF || !ok || pc !== 10'h000 || mem_addr !== 10'h000) begin
            bad++; $display("FAIL pc_wrap: from=%h pc=%h addr=%h want 3ff/000/000", a, pc, mem_addr);
        end
    endtask

    task automatic test_halt();
        int reqSeen;
        mem_ack = 1'b1; mem_rdata = 18'h0BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        halt = 1'b1;
        total++; if (wr_IR !== 1'b1) begin
            bad++; $display("FAIL halt_load: wr_IR=%b want 1", wr_IR);
        end
        @(negedge clk);
        @(negedge clk);
        total++; if (ir_valid !== 1'b1) begin
            bad++; $display("FAIL halt_completes: ir_valid=%b want 1", ir_valid);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        total++; if (pc !== 10'h001 || busy !== 1'b0 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL halt_idle: pc=%h busy=%b mem_req=%b want 001/0/0", pc, busy, mem_req);
        end
        reqSeen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req) reqSeen++;
        end
        total++; if (reqSeen !== 0) begin
            bad++; $display("FAIL halt_holds: mem_req cycles=%0d want 0", reqSeen);
        end
        halt = 1'b0;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== 10'h001) begin
            bad++; $display("FAIL halt_resume: mem_req=%b addr=%h want 1/001", mem_req, mem_addr);
        end
    endtask

    task automatic test_async_reset();
        mem_ack = 1'b1; mem_rdata = 18'h1CAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (re_IR !== 1'b1 || IRin !== 18'h1CAFE) begin
            bad++; $display("FAIL pre_reset_latch: re=%b IRin=%h want 1/1cafe", re_IR, IRin);
        end
        #2 rst = 1'b0;
        #1;
        total++; if ({mem_req, wr_IR, re_IR, ir_valid, busy, fault} !== 6'b0 || pc !== 10'h000 || IRin !== 18'h0) begin
            bad++; $display("FAIL async_reset: strobes=%b pc=%h IRin=%h want 0", {mem_req, wr_IR, re_IR, ir_valid, busy, fault}, pc, IRin);
        end
        run = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        total++; if (busy !== 1'b0 || wr_IR !== 1'b0 || IRin !== 18'h0) begin
            bad++; $display("FAIL stray_ack: busy=%b wr=%b IRin=%h want 0/0/0", busy, wr_IR, IRin);
        end
    endtask

    task automatic test_timeout();
        int reqCycles;
        run = 1'b1;
        @(negedge clk);
        reqCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (fault) break;
            if (mem_req) reqCycles++;
            @(negedge clk);
        end
        total++; if (fault !== 1'b1 || reqCycles !== 15) begin
            bad++; $display("FAIL timeout: fault=%b mem_req cycles=%0d want 1/15", fault, reqCycles);
        end
        total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL fault_outputs: busy=%b mem_req=%b want 0/0", busy, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 18'h3AAAA; exec_done = 1'b1;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0; exec_done = 1'b0;
        total++; if (fault !== 1'b1 || wr_IR !== 1'b0 || pc !== 10'h000 || IRin !== 18'h0) begin
            bad++; $display("FAIL fault_sticky: fault=%b wr=%b pc=%h IRin=%h want 1/0/000/0", fault, wr_IR, pc, IRin);
        end
        rst = 1'b0; run = 1'b0;
        #1;
        total++; if (fault !== 1'b0) begin
            bad++; $display("FAIL fault_clear: fault=%b want 0", fault);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_straight_line();
        test_branch();
        test_halt();
        test_async_reset();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
